mips_boot_sequencer: RTL and testbench

//  Synthesizable replacement for hand-scripted program loading into iitk_mini_mips.

---
 rtl/mips_boot_pkg.sv | 23 ++
 rtl/mips_boot_watchdog.sv | 28 ++
 rtl/mips_boot_sequencer.sv | 152 +++++++++++++++
 tb/tb_mips_boot_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the iitk_mini_mips boot sequencer.
// ST_FAULT exists only when MIPS_BOOT_PC_CHECK_EN is defined.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
`ifdef MIPS_BOOT_PC_CHECK_EN
    , ST_FAULT
`endif
  } boot_state_t;

  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;

  // The core's reset input is active-high.
  localparam logic CORE_RST_ON  = 1'b1;
  localparam logic CORE_RST_OFF = ~CORE_RST_ON;

endpackage

// File: rtl/mips_boot_watchdog.sv
// Saturating run-cycle counter with synchronous clear and an expiry flag at MAX_CYCLES-1.
module mips_boot_watchdog #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mips_boot_sequencer.sv
// Boot sequencer: streams a program into iitk_mini_mips through its init port, then runs it to a halt PC.
// Define MIPS_BOOT_PC_CHECK_EN to add the text-segment PC range check and the FAULT exit.
module mips_boot_sequencer
  import mips_boot_pkg::*;
#(
  parameter int unsigned ADDR_W        = 12,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned MAX_CYCLES    = 1000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [31:0] TEXT_BASE     = TEXT_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [31:0]       halt_pc,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              core_reset,
  output logic              core_init_mode,
  output logic              core_write_enable,
  output logic [ADDR_W-1:0] core_init_address,
  output logic [DATA_W-1:0] core_init_instruction,
  input  logic [31:0]       core_pc,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              pc_fault,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam logic [ADDR_W:0]  MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam int unsigned      SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  if ((SETTLE_CYCLES < 1) || (MAX_CYCLES < 1) || (TEXT_BASE[1:0] != 2'b00)) begin : g_bad_param
    $error("mips_boot_sequencer: illegal parameter set");
  end

  boot_state_t      state, state_next;
  logic [ADDR_W:0]  len_q, index_q;
  logic [31:0]      halt_q;
  logic [SET_W-1:0] settle_q;
  logic             waiting, start_ok, launch, handshake, last_word, halt_hit;
  logic             run_en, wd_expired;

  assign waiting   = (state != ST_LOAD) && (state != ST_SETTLE) && (state != ST_RUN);
  assign start_ok  = start && (prog_len != '0) && (prog_len <= MAX_LEN);
  assign launch    = waiting && start_ok;
  assign handshake = (state == ST_LOAD) && host_valid && host_ready;
  assign last_word = ((index_q + ONE) == len_q);
  assign halt_hit  = (core_pc == halt_q);
  assign run_en    = (state == ST_RUN);

`ifdef MIPS_BOOT_PC_CHECK_EN
  logic [31:0] text_end;
  logic        pc_bad;

  assign text_end = TEXT_BASE + (32'(len_q) << 2);
  assign pc_bad   = (core_pc < TEXT_BASE) || (core_pc >= text_end);
`endif

  mips_boot_watchdog #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (launch),
    .enable  (run_en),
    .count   (run_cycles),
    .expired (wd_expired)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD:   if (handshake && last_word) state_next = ST_SETTLE;
      ST_SETTLE: if (settle_q == SET_LAST)   state_next = ST_RUN;
      ST_RUN: begin
        if (halt_hit) state_next = ST_DONE;
`ifdef MIPS_BOOT_PC_CHECK_EN
        else if (pc_bad) state_next = ST_FAULT;
`endif
        else if (wd_expired) state_next = ST_TIMEOUT;
      end
      default:   if (launch) state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= ST_IDLE;
      host_ready            <= 1'b0;
      busy                  <= 1'b0;
      core_reset            <= CORE_RST_ON;
      core_init_mode        <= 1'b1;
      core_write_enable     <= 1'b0;
      core_init_address     <= '0;
      core_init_instruction <= '0;
      done                  <= 1'b0;
      timeout               <= 1'b0;
      len_q                 <= '0;
      index_q               <= '0;
      halt_q                <= '0;
      settle_q              <= '0;
    end else begin
      state             <= state_next;
      host_ready        <= (state_next == ST_LOAD);
      busy              <= (state_next == ST_LOAD) || (state_next == ST_SETTLE) ||
                           (state_next == ST_RUN);
      core_reset        <= (state_next == ST_RUN) ? CORE_RST_OFF : CORE_RST_ON;
      // init mode stays up for the cycle that writes the final word
      core_init_mode    <= (state_next == ST_IDLE) || (state_next == ST_LOAD) || handshake;
      core_write_enable <= handshake;
      settle_q          <= (state == ST_SETTLE) ? settle_q + SET_W'(1) : '0;
      if (handshake) begin
        core_init_address     <= index_q[ADDR_W-1:0];
        core_init_instruction <= host_data;
        index_q               <= index_q + ONE;
      end
      if (launch) begin
        len_q   <= prog_len;
        halt_q  <= halt_pc;
        index_q <= '0;
        done    <= 1'b0;
        timeout <= 1'b0;
      end else begin
        if (run_en && (state_next == ST_DONE))    done    <= 1'b1;
        if (run_en && (state_next == ST_TIMEOUT)) timeout <= 1'b1;
      end
    end
  end

`ifdef MIPS_BOOT_PC_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_fault <= 1'b0;
    end else if (launch) begin
      pc_fault <= 1'b0;
    end else if (run_en && (state_next == ST_FAULT)) begin
      pc_fault <= 1'b1;
    end
  end
`else
  assign pc_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mips_boot_sequencer.sv
// Self-checking bench for mips_boot_sequencer: scoreboarded program load, settle, halt, timeout, reset and PC-check scenarios.
module tb_mips_boot_sequencer;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned MAXC   = 50;
  localparam int unsigned SETTLE = 2;
  localparam logic [31:0] TBASE  = 32'h0040_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   prog_len = '0;
  logic [31:0]       halt_pc = '0;
  logic              host_valid = 1'b0;
  logic [DATA_W-1:0] host_data = '0;
  logic              host_ready;
  logic              core_reset, core_init_mode, core_write_enable;
  logic [ADDR_W-1:0] core_init_address;
  logic [DATA_W-1:0] core_init_instruction;
  logic [31:0]       core_pc = TBASE;
  logic              busy, done, timeout, pc_fault;
  logic [CNT_W-1:0]  run_cycles;

  always #5 clk = ~clk;

  mips_boot_sequencer #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .CNT_W         (CNT_W),
    .MAX_CYCLES    (MAXC),
    .SETTLE_CYCLES (SETTLE),
    .TEXT_BASE     (TBASE)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .prog_len              (prog_len),
    .halt_pc               (halt_pc),
    .host_valid            (host_valid),
    .host_data             (host_data),
    .host_ready            (host_ready),
    .core_reset            (core_reset),
    .core_init_mode        (core_init_mode),
    .core_write_enable     (core_write_enable),
    .core_init_address     (core_init_address),
    .core_init_instruction (core_init_instruction),
    .core_pc               (core_pc),
    .busy                  (busy),
    .done                  (done),
    .timeout               (timeout),
    .pc_fault              (pc_fault),
    .run_cycles            (run_cycles)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] prog [0:4];
  int          total  = 0;
  int          passed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input logic [31:0] hp);
    start    = 1'b1;
    prog_len = len[ADDR_W:0];
    halt_pc  = hp;
    tick();
    start    = 1'b0;
  endtask

  // Drives n words (gap idle cycles after each handshake); expected writes go to the
  // scoreboard on the handshake and are popped when the DUT presents the write.
  task automatic load_and_score(input int n, input int gap, output int writes);
    int  sent, cyc, idle;
    wr_t e;
    sent = 0; cyc = 0; idle = 0; writes = 0;
    forever begin
      if (core_write_enable === 1'b1) begin
        writes++;
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL load_write: unexpected write addr=%0d data=%h", core_init_address, core_init_instruction);
        end else begin
          e = exp_q.pop_front();
          if (core_init_address !== e.addr || core_init_instruction !== e.data)
            $display("FAIL load_write: got addr=%0d data=%h, want addr=%0d data=%h",
                     core_init_address, core_init_instruction, e.addr, e.data);
          else
            passed++;
        end
      end
      if (sent == n && exp_q.size() == 0) break;
      if (cyc >= 300) begin
        total++;
        $display("FAIL load_budget: sent=%0d of %0d, pending=%0d", sent, n, exp_q.size());
        break;
      end
      host_valid = (sent < n) && (idle == 0);
      if (sent < n) host_data = prog[sent];
      if (host_valid && host_ready === 1'b1) begin
        e.addr = sent[ADDR_W-1:0];
        e.data = prog[sent];
        exp_q.push_back(e);
        sent++;
        idle = gap;
      end else if (idle > 0) begin
        idle--;
      end
      tick();
      cyc++;
    end
    host_valid = 1'b0;
  endtask

  task automatic wait_run(output int settle);
    settle = 0;
    while (core_reset !== 1'b0 && settle < 50) begin
      tick();
      settle++;
    end
  endtask

  task automatic run_pc_walk(output int k);
    k = 0;
    while (done !== 1'b1 && timeout !== 1'b1 && pc_fault !== 1'b1 && k < 200) begin
      core_pc = TBASE + 32'(4 * k);
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({core_reset, core_init_mode, core_write_enable, host_ready, busy, done, timeout, pc_fault} !== 8'b1100_0000)
      $display("FAIL reset_flags: got %b, want 11000000",
               {core_reset, core_init_mode, core_write_enable, host_ready, busy, done, timeout, pc_fault});
    else passed++;
    total++;
    if (core_init_address !== '0 || core_init_instruction !== '0 || run_cycles !== '0)
      $display("FAIL reset_values: addr=%0d instr=%h run=%0d, want 0/0/0",
               core_init_address, core_init_instruction, run_cycles);
    else passed++;
    reset = 1'b1;
    tick();
    total++;
    if (host_ready !== 1'b0 || busy !== 1'b0 || core_reset !== 1'b1)
      $display("FAIL idle_after_reset: ready=%b busy=%b core_reset=%b, want 0/0/1", host_ready, busy, core_reset);
    else passed++;
  endtask

  task automatic test_basic_load();
    int writes, k, extra;
    core_pc = TBASE;
    do_start(5, 32'h0040_0014);
    total++;
    if (host_ready !== 1'b1 || busy !== 1'b1 || core_init_mode !== 1'b1)
      $display("FAIL basic_load_entry: ready=%b busy=%b mode=%b, want 1/1/1", host_ready, busy, core_init_mode);
    else passed++;
    load_and_score(5, 0, writes);
    total++;
    if (writes !== 5) $display("FAIL basic_write_count: got %0d, want 5", writes);
    else passed++;
    // an extra word offered after the last one must never be taken
    host_valid = 1'b1;
    host_data  = 32'hDEAD_BEEF;
    k = 0; extra = 0;
    while (core_reset !== 1'b0 && k < 50) begin
      tick();
      k++;
      if (core_write_enable === 1'b1) extra++;
    end
    host_valid = 1'b0;
    total++;
    if (k !== SETTLE) $display("FAIL basic_settle: core_reset fell after %0d cycles, want %0d", k, SETTLE);
    else passed++;
    total++;
    if (extra !== 0) $display("FAIL basic_extra_word: %0d extra writes, want 0", extra);
    else passed++;
    total++;
    if (core_init_mode !== 1'b0 || host_ready !== 1'b0 || run_cycles !== '0)
      $display("FAIL basic_run_entry: mode=%b ready=%b run=%0d, want 0/0/0", core_init_mode, host_ready, run_cycles);
    else passed++;
    run_pc_walk(k);
    total++;
    if (done !== 1'b1 || k !== 6) $display("FAIL basic_halt: done=%b after %0d cycles, want 1 after 6", done, k);
    else passed++;
    total++;
    if (run_cycles !== 6 || core_reset !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0)
      $display("FAIL basic_done_state: run=%0d core_reset=%b busy=%b timeout=%b, want 6/1/0/0",
               run_cycles, core_reset, busy, timeout);
    else passed++;
  endtask

  task automatic test_gapped_valid();
    int writes, s, k;
    do_start(5, 32'h0040_0014);
    load_and_score(5, 2, writes);
    total++;
    if (writes !== 5) $display("FAIL gap_write_count: got %0d, want 5", writes);
    else passed++;
    wait_run(s);
    total++;
    if (s !== SETTLE) $display("FAIL gap_settle: got %0d, want %0d", s, SETTLE);
    else passed++;
    run_pc_walk(k);
    total++;
    if (done !== 1'b1 || run_cycles !== 6) $display("FAIL gap_halt: done=%b run=%0d, want 1/6", done, run_cycles);
    else passed++;
  endtask

  task automatic test_timeout();
    int writes, s, k;
    core_pc = 32'h0040_0008;
    do_start(3, 32'h0040_0014);
    load_and_score(3, 0, writes);
    wait_run(s);
    total++;
    if (s !== SETTLE) $display("FAIL timeout_settle: got %0d, want %0d", s, SETTLE);
    else passed++;
    k = 0;
    while (timeout !== 1'b1 && done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    total++;
    if (timeout !== 1'b1 || k !== MAXC) $display("FAIL timeout_cycles: timeout=%b after %0d, want 1 after %0d", timeout, k, MAXC);
    else passed++;
    total++;
    if (run_cycles !== MAXC || core_reset !== 1'b1 || done !== 1'b0 || pc_fault !== 1'b0)
      $display("FAIL timeout_state: run=%0d core_reset=%b done=%b fault=%b, want %0d/1/0/0",
               run_cycles, core_reset, done, pc_fault, MAXC);
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    int writes, s, k;
    core_pc = TBASE;
    do_start(5, 32'h0040_0014);
    load_and_score(2, 0, writes);
    total++;
    if (writes !== 2 || core_init_address !== 1) $display("FAIL midreset_partial: writes=%0d addr=%0d, want 2/1", writes, core_init_address);
    else passed++;
    #3 reset = 1'b0;
    #1;
    total++;
    if ({core_reset, core_init_mode, core_write_enable, host_ready, busy, done, timeout, pc_fault} !== 8'b1100_0000 ||
        core_init_address !== '0 || core_init_instruction !== '0 || run_cycles !== '0)
      $display("FAIL midreset_async: flags=%b addr=%0d instr=%h run=%0d, want 11000000/0/0/0",
               {core_reset, core_init_mode, core_write_enable, host_ready, busy, done, timeout, pc_fault},
               core_init_address, core_init_instruction, run_cycles);
    else passed++;
    tick();
    reset = 1'b1;
    tick();
    do_start(5, 32'h0040_0014);
    load_and_score(5, 0, writes);
    total++;
    if (writes !== 5) $display("FAIL midreset_reload: writes=%0d, want 5", writes);
    else passed++;
    wait_run(s);
    run_pc_walk(k);
    total++;
    if (done !== 1'b1 || run_cycles !== 6) $display("FAIL midreset_halt: done=%b run=%0d, want 1/6", done, run_cycles);
    else passed++;
  endtask

  task automatic test_illegal_start();
    do_start(0, 32'h0040_0014);
    total++;
    if (host_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b1)
      $display("FAIL illegal_len0: ready=%b busy=%b done=%b, want 0/0/1", host_ready, busy, done);
    else passed++;
    do_start((1 << ADDR_W) + 1, 32'h0040_0014);
    total++;
    if (host_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b1)
      $display("FAIL illegal_len_big: ready=%b busy=%b done=%b, want 0/0/1", host_ready, busy, done);
    else passed++;
  endtask

  task automatic test_start_during_run();
    int writes, s, k;
    core_pc = 32'h0040_0004;
    do_start(3, 32'h0040_0014);
    load_and_score(3, 0, writes);
    wait_run(s);
    repeat (3) tick();
    start    = 1'b1;
    prog_len = 2;
    tick();
    start    = 1'b0;
    k = 4;
    total++;
    if (busy !== 1'b1 || host_ready !== 1'b0 || core_reset !== 1'b0 || run_cycles !== 4)
      $display("FAIL run_start_ignored: busy=%b ready=%b core_reset=%b run=%0d, want 1/0/0/4",
               busy, host_ready, core_reset, run_cycles);
    else passed++;
    while (timeout !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    total++;
    if (timeout !== 1'b1 || k !== MAXC || run_cycles !== MAXC)
      $display("FAIL run_start_timeout: timeout=%b k=%0d run=%0d, want 1/%0d/%0d", timeout, k, run_cycles, MAXC, MAXC);
    else passed++;
  endtask

  task automatic test_pc_range();
    int writes, s, k;
    core_pc = TBASE;
    do_start(3, 32'h0040_0014);
    load_and_score(3, 0, writes);
    wait_run(s);
    core_pc = 32'h0050_0000;
    tick();
`ifdef MIPS_BOOT_PC_CHECK_EN
    total++;
    if (pc_fault !== 1'b1 || core_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL pc_fault_set: fault=%b core_reset=%b busy=%b done=%b, want 1/1/0/0", pc_fault, core_reset, busy, done);
    else passed++;
    do_start(1, TBASE);
    total++;
    if (pc_fault !== 1'b0 || host_ready !== 1'b1) $display("FAIL pc_fault_clear: fault=%b ready=%b, want 0/1", pc_fault, host_ready);
    else passed++;
    load_and_score(1, 0, writes);
    wait_run(s);
    run_pc_walk(k);
`else
    repeat (2) tick();
    total++;
    if (pc_fault !== 1'b0 || busy !== 1'b1 || core_reset !== 1'b0)
      $display("FAIL pc_nocheck: fault=%b busy=%b core_reset=%b, want 0/1/0", pc_fault, busy, core_reset);
    else passed++;
    k = 0;
    while (timeout !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    total++;
    if (timeout !== 1'b1 || pc_fault !== 1'b0) $display("FAIL pc_nocheck_end: timeout=%b fault=%b, want 1/0", timeout, pc_fault);
    else passed++;
`endif
  endtask

  initial begin
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_000A;
    prog[2] = 32'h0109_5020;
    prog[3] = 32'h200B_0000;
    prog[4] = 32'h0109_602A;
    test_reset();
    test_basic_load();
    test_gapped_valid();
    test_timeout();
    test_reset_mid_load();
    test_illegal_start();
    test_start_during_run();
    test_pc_range();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
